// File: rtl/mux2_rr_arbiter_if.sv
// mux2_rr_arbiter_if: valid/ready beat stream carrying data and a packet-last flag
interface mux2_rr_arbiter_if #(parameter int DW = 8);
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
    logic          ready;
    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: packet-based round-robin sharing of one stream channel between two requesters
module mux2_rr_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux2_rr_arbiter_if.slave      i0,
    mux2_rr_arbiter_if.slave      i1,
    mux2_rr_arbiter_if.master     y,
    output logic                  sel,
    output logic                  busy
);
    localparam int BW = $clog2(MAX_BURST) + 1;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t          state, next_state;
    logic            last_winner;
    logic [BW-1:0]   beat_cnt;
    logic [DW-1:0]   mux_data;
    logic            xfer, own_last, rel;
    assign xfer     = y.valid & y.ready;
    assign own_last = (state == OWN1) ? i1.last : i0.last;
    // a grant ends on the owner's last beat or when the burst cap is reached
    assign rel      = xfer & (own_last | (beat_cnt == BW'(MAX_BURST - 1)));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= 1'b0;
            last_winner <= 1'b1;
            beat_cnt    <= '0;
        end else begin
            state <= next_state;
            sel   <= (next_state == OWN1) ? 1'b1 : (next_state == OWN0) ? 1'b0 : sel;
            if (rel) begin
                last_winner <= (state == OWN1);
                beat_cnt    <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
    always_comb begin
        next_state = state;
        if (state == IDLE)
            next_state = (i0.valid & i1.valid) ? (last_winner ? OWN0 : OWN1) :
                         i0.valid ? OWN0 : i1.valid ? OWN1 : IDLE;
        else if (rel)
            next_state = (state == OWN0) ? (i1.valid ? OWN1 : IDLE) : (i0.valid ? OWN0 : IDLE);
    end
    always_comb begin
        mux_data = sel ? i1.data : i0.data;
        y.data   = mux_data;
        y.valid  = (state == OWN0) ? i0.valid : (state == OWN1) ? i1.valid : 1'b0;
        y.last   = (state == OWN0) ? i0.last  : (state == OWN1) ? i1.last  : 1'b0;
        i0.ready = (state == OWN0) & y.ready;
        i1.ready = (state == OWN1) & y.ready;
        busy     = (state != IDLE);
    end
endmodule
